mem_lsu: RTL and testbench

Load/store unit sitting directly upstream of the MEM-stage data memory, between the EX/MEM pipeline register and the word-only memory array. It aligns and sign/zero-extends load data. It performs byte/halfword stores as a two-cycle read-modify-write, stalling the pipeline for one cycle. It flags misaligned, out-of-range and illegal accesses so that no memory access occurs for them.

---
 rtl/mem_lsu.sv | 174 +++++++++++++++++
 tb/tb_mem_lsu.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu
// Purpose  : MEM-stage load/store unit: load alignment/extension, byte/half
//            stores via two-cycle read-modify-write, access fault screening.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lsu #(
    parameter int MEM_ADDR_W = 13
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_storeData,
    input  logic [1:0]  i_ctrlMEM,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_memReadData,
    output logic [31:0] o_memAddr,
    output logic [31:0] o_memWriteData,
    output logic [1:0]  o_memCtrl,
    output logic [31:0] o_loadData,
    output logic        o_stall,
    output logic        o_exception
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } state_t;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_addr;
    logic [15:0] r_store_lo;
    logic [1:0]  r_size;
    logic        w_latch;

    logic        w_req;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_oob;
    logic        w_bad_f3;
    logic        w_misaligned;
    logic        w_exc;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_fmt;
    logic [31:0] w_merged;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_store_lo <= '0;
            r_size     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_addr     <= i_addr;
                r_store_lo <= i_storeData[15:0];
                r_size     <= i_funct3[1:0];
            end
        end
    end

    // Request decode and access screening
    always_comb begin
        w_req      = i_valid && (i_ctrlMEM != 2'b00);
        w_is_load  = (i_ctrlMEM == 2'b10);
        w_is_store = (i_ctrlMEM == 2'b01);
        w_oob      = ((i_addr >> MEM_ADDR_W) != 32'd0);
        w_bad_f3   = 1'b0;
        if (w_is_load)
            w_bad_f3 = !(i_funct3 inside {c_F3_B, c_F3_H, c_F3_W, c_F3_BU, c_F3_HU});
        else if (w_is_store)
            w_bad_f3 = !(i_funct3 inside {c_F3_B, c_F3_H, c_F3_W});
        w_misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                       ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
        w_exc = w_req && ((i_ctrlMEM == 2'b11) || w_oob || w_bad_f3 || w_misaligned);
    end

    // Load alignment and extension
    always_comb begin
        case (i_addr[1:0])
            2'd0:    w_byte = i_memReadData[7:0];
            2'd1:    w_byte = i_memReadData[15:8];
            2'd2:    w_byte = i_memReadData[23:16];
            default: w_byte = i_memReadData[31:24];
        endcase
        w_half = i_addr[1] ? i_memReadData[31:16] : i_memReadData[15:0];
        case (i_funct3)
            c_F3_B:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  w_load_fmt = {{16{w_half[15]}}, w_half};
            c_F3_BU: w_load_fmt = {24'd0, w_byte};
            c_F3_HU: w_load_fmt = {16'd0, w_half};
            default: w_load_fmt = i_memReadData;
        endcase
    end

    // Merge latched byte/half into the old word held by memory
    always_comb begin
        w_merged = i_memReadData;
        if (r_size == 2'b00) begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_store_lo[7:0];
                2'd1:    w_merged[15:8]  = r_store_lo[7:0];
                2'd2:    w_merged[23:16] = r_store_lo[7:0];
                default: w_merged[31:24] = r_store_lo[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merged[31:16] = r_store_lo;
        end else begin
            w_merged[15:0] = r_store_lo;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_latch        = 1'b0;
        o_memAddr      = {i_addr[31:2], 2'b00};
        o_memWriteData = '0;
        o_memCtrl      = 2'b00;
        o_loadData     = '0;
        o_stall        = 1'b0;
        o_exception    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_exc) begin
                    o_exception = 1'b1;
                end else if (w_req && w_is_load) begin
                    o_memCtrl  = 2'b10;
                    o_loadData = w_load_fmt;
                end else if (w_req && w_is_store) begin
                    if (i_funct3 == c_F3_W) begin
                        o_memCtrl      = 2'b01;
                        o_memWriteData = i_storeData;
                    end else begin
                        o_memCtrl    = 2'b10;
                        o_stall      = 1'b1;
                        w_latch      = 1'b1;
                        w_next_state = RMW_WRITE;
                    end
                end
            end
            RMW_WRITE: begin
                o_memAddr      = {r_addr[31:2], 2'b00};
                o_memCtrl      = 2'b01;
                o_memWriteData = w_merged;
                w_next_state   = IDLE;
            end
            default: w_next_state = IDLE;
        endcase

        // Reset kills any in-flight write immediately, not at the next edge
        if (!i_reset_n) begin
            o_memAddr      = '0;
            o_memWriteData = '0;
            o_memCtrl      = 2'b00;
            o_loadData     = '0;
            o_stall        = 1'b0;
            o_exception    = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_lsu
// Purpose  : Directed, table-driven bench for mem_lsu with a word memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [1:0]  ctrl;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_ctrl;
    logic [31:0] load_data;
    logic        stall;
    logic        exc;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:2047];

    mem_lsu #(.MEM_ADDR_W(13)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_valid        (valid),
        .i_addr         (addr),
        .i_storeData    (sdata),
        .i_ctrlMEM      (ctrl),
        .i_funct3       (f3),
        .i_memReadData  (rdata),
        .o_memAddr      (mem_addr),
        .o_memWriteData (mem_wdata),
        .o_memCtrl      (mem_ctrl),
        .o_loadData     (load_data),
        .o_stall        (stall),
        .o_exception    (exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: reads land on negedge and hold, writes on posedge
    always @(negedge clk) if (mem_ctrl == 2'b10) rdata <= mem[mem_addr[12:2]];
    always @(posedge clk) if (mem_ctrl == 2'b01) mem[mem_addr[12:2]] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Apply inputs just after posedge, then settle past the negedge read
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] c, input logic [2:0] fn);
        @(posedge clk);
        #1;
        valid = v; addr = a; sdata = d; ctrl = c; f3 = fn;
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic        v;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  c;
        logic [2:0]  fn;
        logic [1:0]  e_ctrl;
        logic        e_exc;
        logic [31:0] e_load;
        logic        chk_addr;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{"LB_107",   1'b1, 32'h107,  32'h0,        2'b10, 3'b000, 2'b10, 1'b0, 32'hFFFFFF80, 1'b1};
        vecs[1]  = '{"LBU_107",  1'b1, 32'h107,  32'h0,        2'b10, 3'b100, 2'b10, 1'b0, 32'h00000080, 1'b1};
        vecs[2]  = '{"LH_106",   1'b1, 32'h106,  32'h0,        2'b10, 3'b001, 2'b10, 1'b0, 32'hFFFF80FF, 1'b1};
        vecs[3]  = '{"LHU_104",  1'b1, 32'h104,  32'h0,        2'b10, 3'b101, 2'b10, 1'b0, 32'h00007F01, 1'b1};
        vecs[4]  = '{"LB_105",   1'b1, 32'h105,  32'h0,        2'b10, 3'b000, 2'b10, 1'b0, 32'h0000007F, 1'b1};
        vecs[5]  = '{"LW_104",   1'b1, 32'h104,  32'h0,        2'b10, 3'b010, 2'b10, 1'b0, 32'h80FF7F01, 1'b1};
        vecs[6]  = '{"LB_104",   1'b1, 32'h104,  32'h0,        2'b10, 3'b000, 2'b10, 1'b0, 32'h00000001, 1'b1};
        vecs[7]  = '{"LW_mis",   1'b1, 32'h101,  32'h0,        2'b10, 3'b010, 2'b00, 1'b1, 32'h0,        1'b0};
        vecs[8]  = '{"SH_mis",   1'b1, 32'h103,  32'hFFFF,     2'b01, 3'b001, 2'b00, 1'b1, 32'h0,        1'b0};
        vecs[9]  = '{"ctrl11",   1'b1, 32'h104,  32'h12345678, 2'b11, 3'b010, 2'b00, 1'b1, 32'h0,        1'b0};
        vecs[10] = '{"oob_2000", 1'b1, 32'h2000, 32'h0,        2'b10, 3'b010, 2'b00, 1'b1, 32'h0,        1'b0};
        vecs[11] = '{"ld_f3_011",1'b1, 32'h104,  32'h0,        2'b10, 3'b011, 2'b00, 1'b1, 32'h0,        1'b0};
        vecs[12] = '{"st_f3_100",1'b1, 32'h104,  32'h5A,       2'b01, 3'b100, 2'b00, 1'b1, 32'h0,        1'b0};
        vecs[13] = '{"novalid",  1'b0, 32'h10A,  32'h99,       2'b01, 3'b010, 2'b00, 1'b0, 32'h0,        1'b1};

        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'hAABBCCDD;
        mem[32'h104 >> 2] = 32'h80FF7F01;
        rdata = 32'h0;

        // Outputs must be forced low during reset even with a live request
        rst_n = 1'b0; valid = 1'b1; addr = 32'h107; sdata = 32'hFFFFFFFF; ctrl = 2'b10; f3 = 3'b000;
        @(negedge clk); #1;
        chk("rst_ctrl",  {30'd0, mem_ctrl}, 32'h0);
        chk("rst_stall", {31'd0, stall},    32'h0);
        chk("rst_exc",   {31'd0, exc},      32'h0);
        chk("rst_load",  load_data,         32'h0);
        chk("rst_addr",  mem_addr,          32'h0);
        chk("rst_wdata", mem_wdata,         32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].c, vecs[i].fn);
            chk({vecs[i].name, "_ctrl"},  {30'd0, mem_ctrl}, {30'd0, vecs[i].e_ctrl});
            chk({vecs[i].name, "_exc"},   {31'd0, exc},      {31'd0, vecs[i].e_exc});
            chk({vecs[i].name, "_stall"}, {31'd0, stall},    32'h0);
            chk({vecs[i].name, "_load"},  load_data,         vecs[i].e_load);
            if (vecs[i].chk_addr)
                chk({vecs[i].name, "_addr"}, mem_addr, {vecs[i].a[31:2], 2'b00});
        end

        // Faulting accesses must not have touched memory
        step(1'b1, 32'h104, 32'h0, 2'b10, 3'b010);
        chk("post_exc_104", load_data, 32'h80FF7F01);
        step(1'b1, 32'h100, 32'h0, 2'b10, 3'b010);
        chk("post_exc_100", load_data, 32'hAABBCCDD);
        step(1'b1, 32'h108, 32'h0, 2'b10, 3'b010);
        chk("novalid_108", load_data, 32'h0);

        // SB 0x102: read cycle then merged write, inputs changed in cycle 2
        step(1'b1, 32'h102, 32'h00000011, 2'b01, 3'b000);
        chk("sb_c1_ctrl",  {30'd0, mem_ctrl}, 32'h2);
        chk("sb_c1_addr",  mem_addr,          32'h100);
        chk("sb_c1_stall", {31'd0, stall},    32'h1);
        step(1'b1, 32'h1F0, 32'hFFFFFFFF, 2'b10, 3'b010);
        chk("sb_c2_ctrl",  {30'd0, mem_ctrl}, 32'h1);
        chk("sb_c2_addr",  mem_addr,          32'h100);
        chk("sb_c2_wdata", mem_wdata,         32'hAA11CCDD);
        chk("sb_c2_stall", {31'd0, stall},    32'h0);
        chk("sb_c2_exc",   {31'd0, exc},      32'h0);
        step(1'b1, 32'h100, 32'h0, 2'b10, 3'b010);
        chk("sb_lw", load_data, 32'hAA11CCDD);

        // SH 0x106 over 0x80FF7F01
        step(1'b1, 32'h106, 32'h00001234, 2'b01, 3'b001);
        chk("sh_c1_stall", {31'd0, stall}, 32'h1);
        step(1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        chk("sh_c2_ctrl",  {30'd0, mem_ctrl}, 32'h1);
        chk("sh_c2_wdata", mem_wdata,         32'h12347F01);
        step(1'b1, 32'h104, 32'h0, 2'b10, 3'b010);
        chk("sh_lw", load_data, 32'h12347F01);

        // SW is a single cycle with no stall
        step(1'b1, 32'h108, 32'hDEADBEEF, 2'b01, 3'b010);
        chk("sw_ctrl",  {30'd0, mem_ctrl}, 32'h1);
        chk("sw_wdata", mem_wdata,         32'hDEADBEEF);
        chk("sw_stall", {31'd0, stall},    32'h0);
        step(1'b1, 32'h108, 32'h0, 2'b10, 3'b010);
        chk("sw_lw", load_data, 32'hDEADBEEF);

        // Back-to-back SB to 0x100 then 0x101
        step(1'b1, 32'h100, 32'h00000022, 2'b01, 3'b000);
        step(1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        chk("b2b_w1", mem_wdata, 32'hAA11CC22);
        step(1'b1, 32'h101, 32'h00000033, 2'b01, 3'b000);
        chk("b2b_c1_stall", {31'd0, stall}, 32'h1);
        step(1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        chk("b2b_w2", mem_wdata, 32'hAA113322);
        step(1'b1, 32'h100, 32'h0, 2'b10, 3'b010);
        chk("b2b_lw", load_data, 32'hAA113322);

        // Reset during RMW_WRITE drops the store
        step(1'b1, 32'h100, 32'h00000055, 2'b01, 3'b000);
        @(posedge clk); #1;
        valid = 1'b0; ctrl = 2'b00;
        chk("rstrmw_pre", {30'd0, mem_ctrl}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstrmw_ctrl",  {30'd0, mem_ctrl}, 32'h0);
        chk("rstrmw_wdata", mem_wdata,         32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b1, 32'h100, 32'h0, 2'b10, 3'b010);
        chk("rstrmw_lw",    load_data,         32'hAA113322);
        chk("rstrmw_stall", {31'd0, stall},    32'h0);
        chk("rstrmw_idle",  {30'd0, mem_ctrl}, 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
